// File: rtl/gray_pkg.sv
// gray_pkg: shared Gray-code helpers for the counter and the async FIFO.
//   bin2gray(b) : b XOR (b >> 1)
//   gray2bin(g) : prefix-XOR inverse, MSB first
// Both work on GRAY_MAX_WIDTH-bit arguments. Narrower values are zero-extended
// on the way in, and the low WIDTH bits of the result are used. This is exact
// because a zero MSB contributes nothing to either transform.
package gray_pkg;

    localparam int GRAY_MIN_WIDTH = 2;
    localparam int GRAY_MAX_WIDTH = 32;

    function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(
        input logic [GRAY_MAX_WIDTH-1:0] b
    );
        return b ^ (b >> 1);
    endfunction

    function automatic logic [GRAY_MAX_WIDTH-1:0] gray2bin(
        input logic [GRAY_MAX_WIDTH-1:0] g
    );
        logic [GRAY_MAX_WIDTH-1:0] b;
        b[GRAY_MAX_WIDTH-1] = g[GRAY_MAX_WIDTH-1];
        for (int i = GRAY_MAX_WIDTH-2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_code_conv.sv
// gray_code_conv: purely combinational binary-to-Gray conversion.
//   bin_i  [WIDTH-1:0] : binary input
//   gray_o [WIDTH-1:0] : bin_i XOR (bin_i >> 1)
module gray_code_conv #(
    parameter int WIDTH = 2
) (
    input  logic [WIDTH-1:0] bin_i,
    output logic [WIDTH-1:0] gray_o
);

    assign gray_o = bin_i ^ (bin_i >> 1);

endmodule

// File: rtl/gray_code_counter.sv
// gray_code_counter: registered Gray-code counter. It is the read-side and
// write-side pointer generator in the async FIFO.
//   rd_clk     : counting clock; all state updates happen on its rising edge
//   not_reset  : asynchronous, active-low reset
//   en         : count enable
//   value      : current Gray count; driven directly from a flop
//   value_next : Gray code that value takes on the next enabled edge (combinational)
//   wrap       : one-cycle registered pulse after value steps from the last code to 0
// Optional macro GRAY_CODE_COUNTER_BIN_OUT_EN:
//   - adds output bin_value, the registered binary count;
//   - adds a simulation assertion that value changes in at most one bit per edge.
module gray_code_counter
    import gray_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  logic             rd_clk,
    input  logic             not_reset,
    input  logic             en,
    output logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] value_next,
`ifdef GRAY_CODE_COUNTER_BIN_OUT_EN
    output logic [WIDTH-1:0] bin_value,
`endif
    output logic             wrap
);

    if (WIDTH < GRAY_MIN_WIDTH || WIDTH > GRAY_MAX_WIDTH) begin : g_bad_width
        $error("gray_code_counter: WIDTH out of range");
    end

    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] value_q, gray_d;
    logic             wrap_q, wrap_d;

    assign bin_d = bin_q + 1'b1;

    gray_code_conv #(.WIDTH(WIDTH)) u_conv (
        .bin_i  (bin_d),
        .gray_o (gray_d)
    );

    // Stepping from the all-ones binary count is the only step that returns to 0.
    assign wrap_d = en && (bin_q == {WIDTH{1'b1}});

    always_ff @(posedge rd_clk or negedge not_reset) begin
        if (!not_reset) begin
            bin_q   <= '0;
            value_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
            if (en) begin
                bin_q   <= bin_d;
                value_q <= gray_d;
            end
        end
    end

    assign value      = value_q;
    assign value_next = gray_d;
    assign wrap       = wrap_q;

`ifdef GRAY_CODE_COUNTER_BIN_OUT_EN
    assign bin_value = bin_q;

    // Every candidate update is exactly one bit away from the current code.
    // Checking against value_next, not $past, keeps this check correct
    // across a reset pulse that occurs between edges.
    a_one_bit_step: assert property (@(posedge rd_clk) disable iff (!not_reset)
        $onehot(value_q ^ value_next));
    a_value_is_gray: assert property (@(posedge rd_clk) disable iff (!not_reset)
        value_q == (bin_q ^ (bin_q >> 1)));
`endif

endmodule

// File: tb/tb_gray_code_counter.sv
`timescale 1ns/1ps
module tb_gray_code_counter;

    logic rd_clk = 1'b0;
    logic not_reset;
    logic en;
    always #5 rd_clk = ~rd_clk;

    logic [1:0] v2, n2;  logic w2;
    logic [2:0] v3, n3;  logic w3;
    logic [3:0] v4, n4;  logic w4;
`ifdef GRAY_CODE_COUNTER_BIN_OUT_EN
    logic [1:0] b2;
    logic [2:0] b3;
    logic [3:0] b4;
`endif

    gray_code_counter #(.WIDTH(2)) u_w2 (
        .rd_clk(rd_clk), .not_reset(not_reset), .en(en),
        .value(v2), .value_next(n2),
`ifdef GRAY_CODE_COUNTER_BIN_OUT_EN
        .bin_value(b2),
`endif
        .wrap(w2));
    gray_code_counter #(.WIDTH(3)) u_w3 (
        .rd_clk(rd_clk), .not_reset(not_reset), .en(en),
        .value(v3), .value_next(n3),
`ifdef GRAY_CODE_COUNTER_BIN_OUT_EN
        .bin_value(b3),
`endif
        .wrap(w3));
    gray_code_counter #(.WIDTH(4)) u_w4 (
        .rd_clk(rd_clk), .not_reset(not_reset), .en(en),
        .value(v4), .value_next(n4),
`ifdef GRAY_CODE_COUNTER_BIN_OUT_EN
        .bin_value(b4),
`endif
        .wrap(w4));

    int vectors = 0;
    int miscompares = 0;

    // Reference model: an integer event count per width, reduced modulo 2^W.
    int   cnt [3];
    logic wrp [3];
    int   wid [3] = '{2, 3, 4};
    logic [2:0] prev3;

    logic [2:0] seq3 [8] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
    logic [1:0] seq2 [5] = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] gray(input int n);
        return 32'(n ^ (n >> 1));
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            cnt[k] = 0;
            wrp[k] = 1'b0;
        end
        prev3 = '0;
    endtask

    task automatic check_all();
        chk("w2.value", 32'(v2), gray(cnt[0]));
        chk("w2.next",  32'(n2), gray((cnt[0] + 1) % 4));
        chk("w2.wrap",  32'(w2), 32'(wrp[0]));
        chk("w3.value", 32'(v3), gray(cnt[1]));
        chk("w3.next",  32'(n3), gray((cnt[1] + 1) % 8));
        chk("w3.wrap",  32'(w3), 32'(wrp[1]));
        chk("w4.value", 32'(v4), gray(cnt[2]));
        chk("w4.next",  32'(n4), gray((cnt[2] + 1) % 16));
        chk("w4.wrap",  32'(w4), 32'(wrp[2]));
`ifdef GRAY_CODE_COUNTER_BIN_OUT_EN
        chk("w2.bin", 32'(b2), 32'(cnt[0]));
        chk("w3.bin", 32'(b3), 32'(cnt[1]));
        chk("w4.bin", 32'(b4), 32'(cnt[2]));
`endif
        chk("w3.onebit", 32'($countones(v3 ^ prev3) <= 1), 32'd1);
        prev3 = v3;
    endtask

    // One clock: drive en mid-cycle, then sample 1ns after the rising edge.
    task automatic step(input logic e);
        @(negedge rd_clk);
        en = e;
        @(posedge rd_clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            if (e) begin
                wrp[k] = (cnt[k] == (1 << wid[k]) - 1);
                cnt[k] = (cnt[k] + 1) % (1 << wid[k]);
            end else begin
                wrp[k] = 1'b0;
            end
        end
        check_all();
    endtask

    // Reset pulse between edges; outputs must clear before any clock edge arrives.
    task automatic async_reset();
        #1 not_reset = 1'b0;
        #1;
        model_reset();
        check_all();
        #1 not_reset = 1'b1;
    endtask

    initial begin
        not_reset = 1'b0;
        en        = 1'b1;
        model_reset();
        repeat (3) @(posedge rd_clk);
        #1;
        check_all();
        @(negedge rd_clk);
        en        = 1'b0;
        not_reset = 1'b1;

        // Table-driven sequences, independent of the arithmetic model.
        for (int i = 0; i < 8; i++) begin
            step(1'b1);
            chk("w3.seq", 32'(v3), 32'(seq3[i]));
            if (i < 5) chk("w2.seq", 32'(v2), 32'(seq2[i]));
            chk("w2.wrap4", 32'(w2), 32'(i == 3 || i == 7));
            chk("w3.wrap8", 32'(w3), 32'(i == 7));
        end

        // Enable gating: hold at 11, then resume to 10.
        async_reset();
        step(1'b1);
        step(1'b1);
        chk("w2.at11", 32'(v2), 32'h3);
        repeat (4) step(1'b0);
        chk("w2.hold", 32'(v2), 32'h3);
        chk("w2.holdnext", 32'(n2), 32'h2);
        step(1'b1);
        chk("w2.resume", 32'(v2), 32'h2);

        // Reset while en is high, with the counter at 110.
        async_reset();
        repeat (4) step(1'b1);
        chk("w3.at110", 32'(v3), 32'h6);
        en = 1'b1;
        async_reset();
        chk("w3.rstclr", 32'(v3), 32'h0);
        step(1'b1);
        chk("w3.after", 32'(v3), 32'h1);

        // 16 consecutive enabled edges give a full wrap for WIDTH=4.
        async_reset();
        repeat (16) step(1'b1);
        chk("w4.full", 32'(v4), 32'h0);
        chk("w4.fullwrap", 32'(w4), 32'h1);

        // Random enable traffic with occasional asynchronous resets.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 49) == 0) async_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
